// File: rtl/decoder_select_sequencer_if.sv
// Request/select bundle between the select sequencer and its requesters/decoder.
// master: the sequencer (drives w/en/busy/grant_done); slave: requesters and decoder.
interface decoder_select_sequencer_if;
    logic [3:0] req;
    logic [1:0] w;
    logic       en;
    logic       busy;
    logic       grant_done;

    modport master (
        input  req,
        output w,
        output en,
        output busy,
        output grant_done
    );

    modport slave (
        output req,
        input  w,
        input  en,
        input  busy,
        input  grant_done
    );
endinterface

// File: rtl/decoder_select_sequencer.sv
// Arbitrates four requests onto a 2-to-4 decoder select with a bounded dwell and an en=0 gap.
// Optional build macro: FIXED_PRIO_EN selects fixed priority (req[0] highest) over round-robin.
module decoder_select_sequencer #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    decoder_select_sequencer_if.master  bus
);

    generate
        if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
            $error("HOLD_CYCLES must be in 1..255");
        end
        if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_gap
            $error("GAP_CYCLES must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [3:0] GAP_LOAD  = 4'(GAP_CYCLES - 1);

    state_t     state_reg, state_next;
    logic [1:0] w_reg, w_next;
    logic       en_reg, en_next;
    logic       busy_reg, busy_next;
    logic       grant_done_reg, grant_done_next;
    logic [1:0] last_ptr_reg, last_ptr_next;
    logic [7:0] hold_cnt_reg, hold_cnt_next;
    logic [3:0] gap_cnt_reg, gap_cnt_next;

    logic [1:0] sel;
    logic       any_req;

    assign any_req = |bus.req;

`ifdef FIXED_PRIO_EN
    always_comb begin
        sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (bus.req[i]) sel = 2'(i);
        end
    end
`else
    // Candidate indices in search order: last_ptr+1, +2, +3, +4 (wrapping mod 4).
    logic [1:0] rr_idx [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rr_idx
            assign rr_idx[gi] = last_ptr_reg + 2'(gi + 1);
        end
    endgenerate

    always_comb begin
        sel = last_ptr_reg;
        for (int i = 3; i >= 0; i--) begin
            if (bus.req[rr_idx[i]]) sel = rr_idx[i];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            w_reg          <= 2'd0;
            en_reg         <= 1'b0;
            busy_reg       <= 1'b0;
            grant_done_reg <= 1'b0;
            last_ptr_reg   <= 2'd3;
            hold_cnt_reg   <= 8'd0;
            gap_cnt_reg    <= 4'd0;
        end else begin
            state_reg      <= state_next;
            w_reg          <= w_next;
            en_reg         <= en_next;
            busy_reg       <= busy_next;
            grant_done_reg <= grant_done_next;
            last_ptr_reg   <= last_ptr_next;
            hold_cnt_reg   <= hold_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        w_next          = w_reg;
        en_next         = en_reg;
        busy_next       = busy_reg;
        grant_done_next = 1'b0;
        last_ptr_next   = last_ptr_reg;
        hold_cnt_next   = hold_cnt_reg;
        gap_cnt_next    = gap_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (any_req) begin
                    state_next    = GRANT;
                    w_next        = sel;
                    en_next       = 1'b1;
                    busy_next     = 1'b1;
                    hold_cnt_next = HOLD_LOAD;
                end
            end
            GRANT: begin
                // Expiry and request drop share one exit so only one grant_done pulse results.
                if (hold_cnt_reg == 8'd0 || !bus.req[w_reg]) begin
                    state_next      = GAP;
                    en_next         = 1'b0;
                    grant_done_next = 1'b1;
                    last_ptr_next   = w_reg;
                    gap_cnt_next    = GAP_LOAD;
                end else begin
                    hold_cnt_next = hold_cnt_reg - 8'd1;
                end
            end
            GAP: begin
                if (gap_cnt_reg == 4'd0) begin
                    if (any_req) begin
                        state_next    = GRANT;
                        w_next        = sel;
                        en_next       = 1'b1;
                        hold_cnt_next = HOLD_LOAD;
                    end else begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                    end
                end else begin
                    gap_cnt_next = gap_cnt_reg - 4'd1;
                end
            end
            default: begin
                state_next = IDLE;
                en_next    = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    assign bus.w          = w_reg;
    assign bus.en         = en_reg;
    assign bus.busy       = busy_reg;
    assign bus.grant_done = grant_done_reg;

endmodule
